// File: rtl/fast_cmd_decoder.sv
// FAST_CMD word aligner and decoder: finds the command boundary on IDLE,
// emits IDLE/L0L1/BCR strobes and keeps the bunch-crossing counter.
module fast_cmd_decoder #(
    parameter logic [7:0] IDLE_PAT   = 8'b10101100,
    parameter logic [7:0] L0L1_PAT   = 8'b10110010,
    parameter logic [7:0] BCR_PAT    = 8'b10011001,
    parameter int         LOCK_CNT   = 16,
    parameter int         UNLOCK_CNT = 4,
    parameter int         BC_MAX     = 3563
) (
    input  logic        clk40,
    input  logic        rst,
    input  logic [7:0]  din,
    output logic        locked,
    output logic [2:0]  align,
    output logic        idle_o,
    output logic        l0l1_o,
    output logic        bcr_o,
    output logic [11:0] bcid,
    output logic        bcr_mismatch,
    output logic [7:0]  err_cnt
);

    typedef enum logic [1:0] {
        SEARCH,
        VERIFY,
        LOCKED
    } state_t;

    state_t      state;
    logic [7:0]  d1;
    logic [7:0]  d2;
    logic [15:0] window;
    logic [3:0]  sh;
    logic [7:0]  w;
    logic        is_idle;
    logic        is_l0l1;
    logic        is_bcr;
    logic        valid;
    logic [7:0]  cnt;
    logic [7:0]  run;
    logic        bcr_seen;
    logic [11:0] bcid_next;

    assign window    = {d2, d1};
    // align=0 selects d2; each step moves one bit later into d1
    assign sh        = 4'd8 - {1'b0, align};
    assign w         = window[sh +: 8];
    assign is_idle   = (w == IDLE_PAT);
    assign is_l0l1   = (w == L0L1_PAT);
    assign is_bcr    = (w == BCR_PAT);
    assign valid     = is_idle | is_l0l1 | is_bcr;
    assign bcid_next = (bcid == 12'(BC_MAX)) ? 12'd0 : bcid + 12'd1;

    always_ff @(posedge clk40) begin
        if (rst) begin
            state        <= SEARCH;
            d1           <= 8'd0;
            d2           <= 8'd0;
            locked       <= 1'b0;
            align        <= 3'd0;
            idle_o       <= 1'b0;
            l0l1_o       <= 1'b0;
            bcr_o        <= 1'b0;
            bcid         <= 12'd0;
            bcr_mismatch <= 1'b0;
            err_cnt      <= 8'd0;
            cnt          <= 8'd0;
            run          <= 8'd0;
            bcr_seen     <= 1'b0;
        end else begin
            d1     <= din;
            d2     <= d1;
            idle_o <= 1'b0;
            l0l1_o <= 1'b0;
            bcr_o  <= 1'b0;
            unique case (state)
                SEARCH: begin
                    bcid <= 12'd0;
                    if (is_idle) begin
                        if (LOCK_CNT == 1) begin
                            state    <= LOCKED;
                            locked   <= 1'b1;
                            cnt      <= 8'd0;
                            run      <= 8'd0;
                            bcr_seen <= 1'b0;
                        end else begin
                            state <= VERIFY;
                            cnt   <= 8'd1;
                        end
                    end else begin
                        align <= align + 3'd1;
                    end
                end
                VERIFY: begin
                    bcid <= 12'd0;
                    if (valid) begin
                        if (cnt == 8'(LOCK_CNT - 1)) begin
                            state    <= LOCKED;
                            locked   <= 1'b1;
                            cnt      <= 8'd0;
                            run      <= 8'd0;
                            bcr_seen <= 1'b0;
                        end else begin
                            cnt <= cnt + 8'd1;
                        end
                    end else begin
                        state <= SEARCH;
                        align <= align + 3'd1;
                        cnt   <= 8'd0;
                    end
                end
                LOCKED: begin
                    if (valid) begin
                        run    <= 8'd0;
                        idle_o <= is_idle;
                        l0l1_o <= is_l0l1;
                        bcr_o  <= is_bcr;
                        if (is_bcr) begin
                            bcid     <= 12'd0;
                            bcr_seen <= 1'b1;
                            // first BCR after lock defines the phase
                            if (bcr_seen && bcid_next != 12'd0)
                                bcr_mismatch <= 1'b1;
                        end else begin
                            bcid <= bcid_next;
                        end
                    end else begin
                        if (err_cnt != 8'hFF)
                            err_cnt <= err_cnt + 8'd1;
                        if (run == 8'(UNLOCK_CNT - 1)) begin
                            state  <= SEARCH;
                            locked <= 1'b0;
                            run    <= 8'd0;
                            bcid   <= 12'd0;
                        end else begin
                            run  <= run + 8'd1;
                            bcid <= bcid_next;
                        end
                    end
                end
                default: begin
                    state <= SEARCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fast_cmd_decoder.sv
// Bench for fast_cmd_decoder: serial command streams at several bit phases,
// strobes checked against a timed scoreboard of expected decodes.
module tb_fast_cmd_decoder;

    localparam logic [7:0] IDLE = 8'b10101100;
    localparam logic [7:0] L0L1 = 8'b10110010;
    localparam logic [7:0] BCR  = 8'b10011001;
    localparam int LOCK_BOUND = 8 + 16 + 2;

    logic        clk40 = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  din = 8'd0;
    logic        locked;
    logic [2:0]  align;
    logic        idle_o;
    logic        l0l1_o;
    logic        bcr_o;
    logic [11:0] bcid;
    logic        bcr_mismatch;
    logic [7:0]  err_cnt;

    typedef struct {
        int kind;
        int t;
    } exp_t;

    exp_t        sb_q[$];
    int          cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;
    bit          sb_on = 1'b0;
    int          sb_from = 0;
    int          bcr_seen = 0;
    int          bcr_cyc = 0;
    int          m_obs;
    int          lock_lat = 23;
    logic [11:0] prev_bcid;
    logic [11:0] pre_bcr_bcid;
    logic [7:0]  prev_cmd = 8'd0;

    fast_cmd_decoder dut (
        .clk40        (clk40),
        .rst          (rst),
        .din          (din),
        .locked       (locked),
        .align        (align),
        .idle_o       (idle_o),
        .l0l1_o       (l0l1_o),
        .bcr_o        (bcr_o),
        .bcid         (bcid),
        .bcr_mismatch (bcr_mismatch),
        .err_cnt      (err_cnt)
    );

    always #5 clk40 = ~clk40;

    always @(posedge clk40) cyc <= cyc + 1;

    // scoreboard: each entry names the strobe due at a given cycle
    always @(negedge clk40) begin
        m_obs = 0;
        if (idle_o === 1'b1) m_obs = 1;
        if (l0l1_o === 1'b1) m_obs = 2;
        if (bcr_o === 1'b1) m_obs = 3;
        if (m_obs != 0) begin
            n_tests++;
            if ($countones({idle_o, l0l1_o, bcr_o}) > 1) begin
                n_fail++;
                $display("FAIL one_hot strobes=%b required at most one", {idle_o, l0l1_o, bcr_o});
            end
        end
        while (sb_q.size() > 0 && sb_q[0].t < cyc) begin
            n_tests++;
            n_fail++;
            $display("FAIL missed_strobe kind=%0d due=%0d now=%0d", sb_q[0].kind, sb_q[0].t, cyc);
            void'(sb_q.pop_front());
        end
        if (sb_q.size() > 0 && sb_q[0].t == cyc) begin
            n_tests++;
            if (m_obs !== sb_q[0].kind) begin
                n_fail++;
                $display("FAIL strobe cyc=%0d got kind %0d required %0d", cyc, m_obs, sb_q[0].kind);
            end
            void'(sb_q.pop_front());
        end else if (sb_on && cyc >= sb_from && m_obs != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_strobe cyc=%0d got kind %0d required 0", cyc, m_obs);
        end
        if (bcr_o === 1'b1) begin
            n_tests++;
            if (bcid !== 12'd0) begin
                n_fail++;
                $display("FAIL bcid_on_bcr got %0d required 0", bcid);
            end
            bcr_seen++;
            bcr_cyc = cyc;
            pre_bcr_bcid = prev_bcid;
        end
        prev_bcid = bcid;
    end

    initial begin
        #800000;
        $display("FAIL watchdog got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic send(input logic [7:0] cmd, input int s, input bit ex);
        logic [15:0] t;
        exp_t e;
        @(posedge clk40);
        #1;
        t = {prev_cmd, cmd} >> s;
        din = t[7:0];
        prev_cmd = cmd;
        if (ex) begin
            e.t = cyc + 3;
            e.kind = 0;
            if (cmd == IDLE) e.kind = 1;
            if (cmd == L0L1) e.kind = 2;
            if (cmd == BCR) e.kind = 3;
            if (e.kind != 0) sb_q.push_back(e);
        end
    endtask

    task automatic send_period(input int n_idle, input int s);
        for (int i = 0; i < n_idle; i++) send(IDLE, s, 1'b1);
        send(L0L1, s, 1'b1);
        send(BCR, s, 1'b1);
    endtask

    task automatic sb_start();
        sb_on = 1'b1;
        sb_from = cyc + 4;
    endtask

    task automatic sb_stop();
        sb_on = 1'b0;
        for (int i = 0; i < 4; i++) send(IDLE, 0, 1'b0);
    endtask

    task automatic do_reset();
        @(posedge clk40);
        #1;
        rst = 1'b1;
        din = 8'd0;
        prev_cmd = 8'd0;
        repeat (3) begin
            @(posedge clk40);
            #1;
        end
        rst = 1'b0;
    endtask

    task automatic lock_up(input int s, input int bound, output int lat);
        lat = -1;
        for (int i = 0; i < bound; i++) begin
            send(IDLE, s, 1'b0);
            if (locked === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if (locked !== 1'b0) begin n_fail++; $display("FAIL reset_locked got %b required 0", locked); end
        n_tests++;
        if (align !== 3'd0) begin n_fail++; $display("FAIL reset_align got %0d required 0", align); end
        n_tests++;
        if ({idle_o, l0l1_o, bcr_o} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_strobes got %b required 000", {idle_o, l0l1_o, bcr_o});
        end
        n_tests++;
        if (bcid !== 12'd0) begin n_fail++; $display("FAIL reset_bcid got %0d required 0", bcid); end
        n_tests++;
        if (bcr_mismatch !== 1'b0) begin n_fail++; $display("FAIL reset_mismatch got %b required 0", bcr_mismatch); end
        n_tests++;
        if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_err got %0d required 0", err_cnt); end
    endtask

    task automatic test_lock_phase0();
        int lat;
        int b0;
        do_reset();
        lock_up(0, 40, lat);
        n_tests++;
        if (lat < 0 || lat > LOCK_BOUND) begin
            n_fail++;
            $display("FAIL lock0_latency got %0d required 0..%0d", lat, LOCK_BOUND);
        end else begin
            lock_lat = lat;
        end
        n_tests++;
        if (align !== 3'd0) begin n_fail++; $display("FAIL lock0_align got %0d required 0", align); end
        b0 = bcr_seen;
        sb_start();
        send_period(126, 0);
        for (int i = 0; i < 4; i++) send(IDLE, 0, 1'b1);
        n_tests++;
        if (bcr_seen != b0 + 1 || bcr_mismatch !== 1'b0) begin
            n_fail++;
            $display("FAIL first_bcr_exempt got bcr=%0d mm=%b required bcr=%0d mm=0", bcr_seen - b0, bcr_mismatch, 1);
        end
        send_period(126, 0);
        for (int i = 0; i < 4; i++) send(IDLE, 0, 1'b1);
        n_tests++;
        if (bcr_seen != b0 + 2 || bcr_mismatch !== 1'b1) begin
            n_fail++;
            $display("FAIL second_bcr_mismatch got bcr=%0d mm=%b required bcr=2 mm=1", bcr_seen - b0, bcr_mismatch);
        end
    endtask

    task automatic test_errors();
        int lat;
        for (int i = 0; i < 30; i++)
            send((i == 5 || i == 12 || i == 20) ? 8'h00 : IDLE, 0, 1'b1);
        for (int i = 0; i < 3; i++) send(IDLE, 0, 1'b1);
        n_tests++;
        if (locked !== 1'b1 || err_cnt !== 8'd3) begin
            n_fail++;
            $display("FAIL three_bad got locked=%b err=%0d required locked=1 err=3", locked, err_cnt);
        end
        sb_stop();
        for (int i = 0; i < 4; i++) send(8'h00, 0, 1'b0);
        for (int i = 0; i < 3; i++) send(IDLE, 0, 1'b0);
        n_tests++;
        if (locked !== 1'b0 || err_cnt !== 8'd7 || bcid !== 12'd0) begin
            n_fail++;
            $display("FAIL four_bad got locked=%b err=%0d bcid=%0d required locked=0 err=7 bcid=0",
                     locked, err_cnt, bcid);
        end
        lock_up(0, 40, lat);
        n_tests++;
        if (lat < 0 || err_cnt !== 8'd7 || align !== 3'd0) begin
            n_fail++;
            $display("FAIL relock got lat=%0d err=%0d align=%0d required lat>=0 err=7 align=0",
                     lat, err_cnt, align);
        end
    endtask

    task automatic test_midreset();
        bit found;
        found = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            send(IDLE, 0, 1'b0);
            if (bcid === 12'd1000) begin
                found = 1'b1;
                break;
            end
        end
        n_tests++;
        if (!found) begin n_fail++; $display("FAIL reach_bcid1000 got %0d required 1000", bcid); end
        @(posedge clk40);
        #1;
        rst = 1'b1;
        @(posedge clk40);
        #1;
        rst = 1'b0;
        n_tests++;
        if (locked !== 1'b0 || bcid !== 12'd0 || err_cnt !== 8'd0 || align !== 3'd0 ||
            {idle_o, l0l1_o, bcr_o} !== 3'b000 || bcr_mismatch !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset got lk=%b bcid=%0d err=%0d al=%0d st=%b mm=%b required all 0",
                     locked, bcid, err_cnt, align, {idle_o, l0l1_o, bcr_o}, bcr_mismatch);
        end
    endtask

    task automatic test_shift3();
        int lat;
        do_reset();
        lock_up(3, 40, lat);
        n_tests++;
        if (lat < 0 || lat > LOCK_BOUND || align !== 3'd3) begin
            n_fail++;
            $display("FAIL lock3 got lat=%0d align=%0d required lat<=%0d align=3", lat, align, LOCK_BOUND);
        end
        sb_start();
        send_period(126, 3);
        send_period(126, 3);
        for (int i = 0; i < 4; i++) send(IDLE, 3, 1'b1);
        n_tests++;
        if (locked !== 1'b1 || align !== 3'd3) begin
            n_fail++;
            $display("FAIL shift3_hold got locked=%b align=%0d required 1 3", locked, align);
        end
        sb_on = 1'b0;
        for (int i = 0; i < 4; i++) send(IDLE, 3, 1'b0);
    endtask

    task automatic test_verify_abort();
        bit saw;
        saw = 1'b0;
        do_reset();
        for (int i = 0; i <= lock_lat + 2; i++) begin
            send((i == lock_lat - 3) ? 8'h00 : IDLE, 0, 1'b0);
            if (i <= lock_lat && locked !== 1'b0) saw = 1'b1;
            if (i == lock_lat) begin
                n_tests++;
                if (align !== 3'd1) begin
                    n_fail++;
                    $display("FAIL abort_align got %0d required 1", align);
                end
            end
        end
        n_tests++;
        if (saw) begin n_fail++; $display("FAIL abort_no_lock got locked=1 required 0"); end
    endtask

    task automatic test_bcid_wrap();
        int lat;
        int b0;
        int k;
        bit hit_top;
        bit hit_zero;
        do_reset();
        lock_up(0, 40, lat);
        b0 = bcr_seen;
        sb_start();
        send_period(3562, 0);
        send_period(3562, 0);
        hit_top = 1'b0;
        hit_zero = 1'b0;
        for (int i = 0; i < 3600; i++) begin
            send(IDLE, 0, 1'b1);
            if (bcr_seen == b0 + 2) begin
                k = cyc - bcr_cyc;
                if (k == 3563) begin
                    hit_top = 1'b1;
                    n_tests++;
                    if (bcid !== 12'd3563) begin n_fail++; $display("FAIL free_top got %0d required 3563", bcid); end
                end
                if (k == 3564) begin
                    hit_zero = 1'b1;
                    n_tests++;
                    if (bcid !== 12'd0) begin n_fail++; $display("FAIL free_wrap got %0d required 0", bcid); end
                    break;
                end
            end
        end
        n_tests++;
        if (!(hit_top && hit_zero)) begin n_fail++; $display("FAIL wrap_reached got %b%b required 11", hit_top, hit_zero); end
        n_tests++;
        if (pre_bcr_bcid !== 12'd3563 || bcr_mismatch !== 1'b0) begin
            n_fail++;
            $display("FAIL bcr_wrap got pre=%0d mm=%b required pre=3563 mm=0", pre_bcr_bcid, bcr_mismatch);
        end
        sb_stop();
    endtask

    initial begin
        test_reset();
        test_lock_phase0();
        test_errors();
        test_midreset();
        test_shift3();
        test_verify_abort();
        test_bcid_wrap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
